// File: rtl/adder_operand_loader_pkg.sv
// Shared definitions for the adder operand loader.
// Holds the FSM state type, the default operand width and the pair counter width.
package adder_operand_loader_pkg;

  localparam int unsigned DEF_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

endpackage : adder_operand_loader_pkg

// File: rtl/adder_operand_loader_if.sv
// Bus between the nibble source / adder stage and the operand loader.
//   in_valid, in_data, in_ready : upstream nibble handshake
//   clear                       : abort the operand pair being assembled
//   op_valid, op_ready, op_byte : packed {B, A} pair toward the adder stage
//   pair_count, busy            : delivered-pair counter and pair-in-flight status
// master = environment side, slave = loader side.
interface adder_operand_loader_if
  import adder_operand_loader_pkg::*;
#(
  parameter int unsigned W = DEF_W
);

  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             clear;
  logic             op_valid;
  logic             op_ready;
  logic [2*W-1:0]   op_byte;
  logic [CNT_W-1:0] pair_count;
  logic             busy;

  modport master (
    output in_valid, in_data, clear, op_ready,
    input  in_ready, op_valid, op_byte, pair_count, busy
  );

  modport slave (
    input  in_valid, in_data, clear, op_ready,
    output in_ready, op_valid, op_byte, pair_count, busy
  );

endinterface : adder_operand_loader_if

// File: rtl/adder_operand_loader.sv
// Collects two W-bit nibbles (A then B) and presents them as one packed
// {B, A} byte to the adder stage, counting delivered pairs modulo 16.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of adder_operand_loader_if (handshakes, clear, status)
// in_ready / op_valid decode the state register only; all other outputs are
// register outputs.
module adder_operand_loader
  import adder_operand_loader_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_operand_loader_if.slave bus
);

  state_e           r_state;
  state_e           w_state_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [CNT_W-1:0] r_pair_count;
  logic             r_busy;

  logic             w_in_ready;
  logic             w_op_valid;
  logic             w_in_xfer;
  logic             w_cap_a;
  logic             w_cap_b;
  logic             w_deliver;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear overrides every handshake
  always_comb begin
    w_state_next = r_state;
    w_in_xfer    = bus.in_valid && w_in_ready;
    w_cap_a      = 1'b0;
    w_cap_b      = 1'b0;
    w_deliver    = 1'b0;
    if (bus.clear) begin
      w_state_next = ST_WAIT_A;
    end else begin
      unique case (r_state)
        ST_WAIT_A: begin
          if (w_in_xfer) begin
            w_cap_a      = 1'b1;
            w_state_next = ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (w_in_xfer) begin
            w_cap_b      = 1'b1;
            w_state_next = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (bus.op_ready) begin
            w_deliver    = 1'b1;
            w_state_next = ST_WAIT_A;
          end
        end
        default: w_state_next = ST_WAIT_A;
      endcase
    end
  end

  // Output decode from state only, so there is no input-to-output path
  always_comb begin
    w_in_ready = 1'b0;
    w_op_valid = 1'b0;
    unique case (r_state)
      ST_WAIT_A:  w_in_ready = 1'b1;
      ST_WAIT_B:  w_in_ready = 1'b1;
      ST_PRESENT: w_op_valid = 1'b1;
      default: begin
        w_in_ready = 1'b0;
        w_op_valid = 1'b0;
      end
    endcase
  end

  // Operand registers, pair counter and busy flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_pair_count <= '0;
      r_busy       <= 1'b0;
    end else begin
      if (w_cap_a) begin
        r_a <= bus.in_data;
      end
      if (w_cap_b) begin
        r_b <= bus.in_data;
      end
      if (w_deliver) begin
        r_pair_count <= r_pair_count + CNT_W'(1);
      end
      // busy tracks the upcoming state so it is a true register output
      r_busy <= (w_state_next != ST_WAIT_A);
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.op_valid   = w_op_valid;
  assign bus.op_byte    = {r_b, r_a};
  assign bus.pair_count = r_pair_count;
  assign bus.busy       = r_busy;

endmodule : adder_operand_loader
